// File: rtl/preg_free_list_pkg.sv
// preg_free_list_pkg: shared sizing constants and physical-register index type for the free list.
package preg_free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_ARCH = 32;
  localparam int PREG_W = $clog2(NUM_PREGS);
  typedef logic [PREG_W-1:0] preg_idx_t;
endpackage

// File: rtl/preg_free_list_if.sv
// preg_free_list_if: allocate/free handshake bundle between rename logic (master) and the free list (slave).
interface preg_free_list_if #(
  parameter int NUM_PREGS = preg_free_list_pkg::NUM_PREGS
) ();
  localparam int IW = $clog2(NUM_PREGS);
  logic          alloc_req0;
  logic          alloc_req1;
  logic          alloc_rdy0;
  logic          alloc_rdy1;
  logic [IW-1:0] alloc_idx0;
  logic [IW-1:0] alloc_idx1;
  logic          free_vld0;
  logic          free_vld1;
  logic [IW-1:0] free_idx0;
  logic [IW-1:0] free_idx1;
  logic [IW:0]   free_count;
  logic          err;
  modport master (
    output alloc_req0, alloc_req1, free_vld0, free_vld1, free_idx0, free_idx1,
    input  alloc_rdy0, alloc_rdy1, alloc_idx0, alloc_idx1, free_count, err
  );
  modport slave (
    input  alloc_req0, alloc_req1, free_vld0, free_vld1, free_idx0, free_idx1,
    output alloc_rdy0, alloc_rdy1, alloc_idx0, alloc_idx1, free_count, err
  );
endinterface

// File: rtl/preg_free_list_priority_encoder.sv
// priority_encoder: finds the lowest set bit and, when two-sided, the highest set bit of a vector.
module priority_encoder #(
  parameter int WIDTH    = 64,
  parameter bit TWO_SIDE = 1'b1
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] out_LSB,
  output logic [$clog2(WIDTH)-1:0] out_MSB,
  output logic                     vld_o
);
  localparam int W = $clog2(WIDTH);
  always_comb begin
    out_LSB = '0;
    out_MSB = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (in_i[i]) out_LSB = W'(i);
    if (TWO_SIDE) for (int i = 0; i < WIDTH; i++) if (in_i[i]) out_MSB = W'(i);
  end
  assign vld_o = |in_i;
endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: bitmap free list offering lowest free preg on port 0 and highest on port 1.
module preg_free_list #(
  parameter int NUM_PREGS = preg_free_list_pkg::NUM_PREGS,
  parameter int NUM_ARCH  = preg_free_list_pkg::NUM_ARCH
) (
  input logic           clk,
  input logic           rst_n,
  preg_free_list_if.slave bus
);
  localparam int IW = $clog2(NUM_PREGS);
  localparam int CW = IW + 1;
  localparam logic [NUM_PREGS-1:0] RST_MAP = ~((NUM_PREGS'(1) << NUM_ARCH) - NUM_PREGS'(1));
  logic [NUM_PREGS-1:0] bm_q, bm_d, set_v, clr_v;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [IW-1:0]        lo, hi;
  logic                 any, rdy0, rdy1, g0, g1, ok0, ok1, bad;
  priority_encoder #(.WIDTH(NUM_PREGS), .TWO_SIDE(1'b1)) u_enc (
    .in_i(bm_q), .out_LSB(lo), .out_MSB(hi), .vld_o(any)
  );
  assign rdy0           = any;
  assign rdy1           = any && (lo != hi);
  assign bus.alloc_rdy0 = rdy0;
  assign bus.alloc_rdy1 = rdy1;
  assign bus.alloc_idx0 = lo;
  assign bus.alloc_idx1 = hi;
  assign bus.free_count = cnt_q;
  assign bus.err        = err_q;
  // A free is only applied to an allocated, non-zero index; port 1 yields to an identical port 0 free.
  always_comb begin
    g0    = bus.alloc_req0 && rdy0;
    g1    = bus.alloc_req1 && rdy1;
    ok0   = bus.free_vld0 && (bus.free_idx0 != '0) && !bm_q[bus.free_idx0];
    ok1   = bus.free_vld1 && (bus.free_idx1 != '0) && !bm_q[bus.free_idx1]
            && !(ok0 && (bus.free_idx1 == bus.free_idx0));
    bad   = (bus.free_vld0 && !ok0) || (bus.free_vld1 && !ok1);
    set_v = (ok0 ? NUM_PREGS'(1) << bus.free_idx0 : '0) | (ok1 ? NUM_PREGS'(1) << bus.free_idx1 : '0);
    clr_v = (g0 ? NUM_PREGS'(1) << lo : '0) | (g1 ? NUM_PREGS'(1) << hi : '0);
    bm_d  = (bm_q | set_v) & ~clr_v & ~NUM_PREGS'(1);
    cnt_d = cnt_q + CW'(ok0) + CW'(ok1) - CW'(g0) - CW'(g1);
    err_d = err_q | bad;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bm_q  <= RST_MAP;
      cnt_q <= CW'(NUM_PREGS - NUM_ARCH);
      err_q <= 1'b0;
    end else begin
      bm_q  <= bm_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list: randomized and directed scoreboard bench against a set-based free-list model.
module tb_preg_free_list;
  import preg_free_list_pkg::*;
  localparam int NP = NUM_PREGS;
  localparam int NA = NUM_ARCH;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  preg_free_list_if #(.NUM_PREGS(NP)) bus ();
  preg_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    bit rdy0;
    bit rdy1;
    int idx0;
    int idx1;
    int cnt;
    bit err;
  } exp_t;
  exp_t q[$];
  bit fm[NP];
  bit er;
  int checks = 0;
  int errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int lowest();
    for (int i = 0; i < NP; i++) if (fm[i]) return i;
    return -1;
  endfunction
  function automatic int highest();
    for (int i = NP - 1; i >= 0; i--) if (fm[i]) return i;
    return -1;
  endfunction
  function automatic int nfree();
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(fm[i]);
    return n;
  endfunction
  function automatic exp_t snap();
    exp_t e;
    int lo = lowest();
    int hi = highest();
    e.rdy0 = lo >= 0;
    e.rdy1 = (lo >= 0) && (lo != hi);
    e.idx0 = lo;
    e.idx1 = hi;
    e.cnt  = nfree();
    e.err  = er;
    return e;
  endfunction
  function automatic int pick();
    int k;
    if ($urandom_range(0, 3) != 0)
      for (int t = 0; t < 16; t++) begin
        k = int'($urandom_range(1, NP - 1));
        if (!fm[k]) return k;
      end
    return int'($urandom_range(0, NP - 1));
  endfunction
  task automatic step(bit rs, bit r0, bit r1, bit v0, int i0, bit v1, int i1);
    bit nf[NP];
    int lo, hi;
    bus.alloc_req0 = r0;
    bus.alloc_req1 = r1;
    bus.free_vld0  = v0;
    bus.free_vld1  = v1;
    bus.free_idx0  = preg_idx_t'(i0);
    bus.free_idx1  = preg_idx_t'(i1);
    rst_n          = rs;
    if (!rs) begin
      for (int i = 0; i < NP; i++) fm[i] = (i >= NA);
      er = 1'b0;
    end else begin
      lo = lowest();
      hi = highest();
      nf = fm;
      if (v0) begin
        if (i0 == 0 || fm[i0]) er = 1'b1;
        else nf[i0] = 1'b1;
      end
      if (v1) begin
        if (i1 == 0 || fm[i1] || (v0 && i1 == i0)) er = 1'b1;
        else nf[i1] = 1'b1;
      end
      if (r0 && lo >= 0) nf[lo] = 1'b0;
      if (r1 && hi >= 0 && hi != lo) nf[hi] = 1'b0;
      fm = nf;
    end
    q.push_back(snap());
    @(posedge clk);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rdy0", int'(bus.alloc_rdy0), int'(e.rdy0));
      chk("rdy1", int'(bus.alloc_rdy1), int'(e.rdy1));
      if (e.rdy0) chk("idx0", int'(bus.alloc_idx0), e.idx0);
      if (e.rdy1) chk("idx1", int'(bus.alloc_idx1), e.idx1);
      chk("free_count", int'(bus.free_count), e.cnt);
      chk("err", int'(bus.err), int'(e.err));
    end
  end
  initial begin
    bus.alloc_req0 = 1'b0;
    bus.alloc_req1 = 1'b0;
    bus.free_vld0  = 1'b0;
    bus.free_vld1  = 1'b0;
    bus.free_idx0  = '0;
    bus.free_idx1  = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_count", int'(bus.free_count), 32);
    chk("reset_idx0", int'(bus.alloc_idx0), 32);
    chk("reset_idx1", int'(bus.alloc_idx1), 63);
    chk("reset_err", int'(bus.err), 0);
    repeat (16) step(1, 1, 1, 0, 0, 0, 0);
    chk("drained_count", int'(bus.free_count), 0);
    chk("drained_rdy0", int'(bus.alloc_rdy0), 0);
    chk("drained_rdy1", int'(bus.alloc_rdy1), 0);
    repeat (2) step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 40, 0, 0);
    chk("one_idx0", int'(bus.alloc_idx0), 40);
    chk("one_rdy1", int'(bus.alloc_rdy1), 0);
    chk("one_count", int'(bus.free_count), 1);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("one_taken_count", int'(bus.free_count), 0);
    step(1, 0, 0, 1, 5, 1, 9);
    chk("pair_idx0", int'(bus.alloc_idx0), 5);
    chk("pair_idx1", int'(bus.alloc_idx1), 9);
    chk("pair_count", int'(bus.free_count), 2);
    step(1, 0, 0, 1, 50, 0, 0);
    chk("free50_err", int'(bus.err), 0);
    step(1, 0, 0, 1, 50, 0, 0);
    chk("dup50_count", int'(bus.free_count), 3);
    chk("dup50_err", int'(bus.err), 1);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("zero_count", int'(bus.free_count), 3);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", int'(bus.err), 1);
    step(1, 0, 0, 1, 7, 1, 7);
    chk("same_idx_count", int'(bus.free_count), 4);
    step(1, 1, 0, 1, 5, 0, 0);
    step(1, 1, 1, 1, 20, 1, 21);
    step(0, 1, 1, 1, 12, 1, 13);
    chk("rst_ovr_count", int'(bus.free_count), 32);
    chk("rst_ovr_err", int'(bus.err), 0);
    chk("rst_ovr_idx0", int'(bus.alloc_idx0), 32);
    chk("rst_ovr_idx1", int'(bus.alloc_idx1), 63);
    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 79) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) == 0, pick(), $urandom_range(0, 2) == 0, pick());
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
